// File: rtl/wb_cpu.sv
// Accumulator CPU with one Wishbone classic master port shared by fetch and data access.
// Build option: define CPU_ILLEGAL_TRAP_EN to halt on the undefined opcode 0x8.
module wb_cpu #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          CLK_I,
    input  logic          RST_I,
    input  logic [AW-1:0] ADR_I,
    output logic [AW-1:0] ADR_O,
    input  logic [DW-1:0] DAT_I,
    output logic [DW-1:0] DAT_O,
    output logic          CYC_O,
    output logic          STB_O,
    output logic          WE_O,
    input  logic          ACK_I,
    output logic [AW-1:0] pc_o,
    output logic          halt_o
);

    // Bus handshake: a transfer completes on the rising edge where STB_O and ACK_I are both high;
    // until then ADR_O, DAT_O and WE_O are held, and ACK_I is ignored while STB_O is low.

    typedef enum logic [2:0] {BOOT, FETCH, MEM, EXEC, HALT} state_t;

    state_t        state;
    logic [AW-1:0] pc;
    logic [DW-1:0] acc;
    logic [DW-1:0] ir;

    logic [3:0]    op;
    logic [3:0]    fetch_op;
    logic [AW-1:0] target;
    logic [AW-1:0] fetch_addr;
    logic [DW-1:0] imm;
    logic          take_branch;
    logic          stop_exec;

    function automatic logic is_mem_op(input logic [3:0] code);
        return ((code >= 4'h2) && (code <= 4'h7)) || (code == 4'hD) || (code == 4'hE);
    endfunction

    assign op          = ir[31:28];
    assign fetch_op    = DAT_I[31:28];
    assign target      = AW'(ir[27:0]);
    assign fetch_addr  = AW'(DAT_I[27:0]);
    assign imm         = {{4{ir[27]}}, ir[27:0]};
    assign take_branch = (op == 4'h9) || ((op == 4'hA) && (acc == '0)) || ((op == 4'hB) && acc[31]);

`ifdef CPU_ILLEGAL_TRAP_EN
    assign stop_exec = (op == 4'hF) || (op == 4'h8);
`else
    assign stop_exec = (op == 4'hF);
`endif

    assign CYC_O = STB_O;
    assign pc_o  = pc;

    // Bus outputs are set up on the edge entering FETCH/MEM so a zero-wait slave can ACK at once.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state  <= BOOT;
            pc     <= '0;
            acc    <= '0;
            ir     <= '0;
            ADR_O  <= '0;
            DAT_O  <= '0;
            STB_O  <= 1'b0;
            WE_O   <= 1'b0;
            halt_o <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    pc    <= ADR_I;
                    ADR_O <= ADR_I;
                    STB_O <= 1'b1;
                    WE_O  <= 1'b0;
                    state <= FETCH;
                end
                FETCH: begin
                    if (ACK_I) begin
                        ir <= DAT_I;
                        pc <= pc + AW'(1);
                        if (is_mem_op(fetch_op)) begin
                            ADR_O <= fetch_addr;
                            WE_O  <= (fetch_op == 4'h3);
                            if (fetch_op == 4'h3) DAT_O <= acc;
                            state <= MEM;
                        end else begin
                            STB_O <= 1'b0;
                            state <= EXEC;
                        end
                    end
                end
                MEM: begin
                    if (ACK_I) begin
                        case (op)
                            4'h2, 4'hE: acc <= DAT_I;
                            4'h4:       acc <= acc + DAT_I;
                            4'h5:       acc <= acc - DAT_I;
                            4'h6:       acc <= acc & DAT_I;
                            4'h7:       acc <= acc | DAT_I;
                            4'hD:       acc <= acc ^ DAT_I;
                            default:    acc <= acc;
                        endcase
                        ADR_O <= pc;
                        WE_O  <= 1'b0;
                        state <= FETCH;
                    end
                end
                EXEC: begin
                    if (op == 4'h1) acc <= imm;
                    else if (op == 4'hC) acc <= acc + imm;
                    if (stop_exec) begin
                        halt_o <= 1'b1;
                        state  <= HALT;
                    end else begin
                        STB_O <= 1'b1;
                        state <= FETCH;
                        if (take_branch) begin
                            pc    <= target;
                            ADR_O <= target;
                        end else begin
                            ADR_O <= pc;
                        end
                    end
                end
                HALT: begin
                    halt_o <= 1'b1;
                end
                default: state <= BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_cpu.sv
// Directed bench for wb_cpu: behavioural Wishbone memory with programmable wait states,
// bus-transaction scoreboard and immediate-assertion checks.
module tb_wb_cpu;

    logic        CLK_I = 1'b0;
    logic        RST_I = 1'b0;
    logic [31:0] ADR_I = 32'h0;
    logic [31:0] ADR_O;
    logic [31:0] DAT_I;
    logic [31:0] DAT_O;
    logic        CYC_O;
    logic        STB_O;
    logic        WE_O;
    logic        ACK_I;
    logic [31:0] pc_o;
    logic        halt_o;

    wb_cpu #(.AW(32), .DW(32)) dut (
        .CLK_I (CLK_I),
        .RST_I (RST_I),
        .ADR_I (ADR_I),
        .ADR_O (ADR_O),
        .DAT_I (DAT_I),
        .DAT_O (DAT_O),
        .CYC_O (CYC_O),
        .STB_O (STB_O),
        .WE_O  (WE_O),
        .ACK_I (ACK_I),
        .pc_o  (pc_o),
        .halt_o(halt_o)
    );

    // clock / reset
    always #5 CLK_I = ~CLK_I;

    // memory model; 0x300 reads return 1 once it has been read once and patch_en is set
    logic [31:0] mem [0:1023];
    int          wait_n    = 0;
    logic        patch_en  = 1'b0;
    int          rd300_cnt = 0;
    int          wcnt      = 0;
    int          stab_err  = 0;
    int          wait_seen = 0;
    logic        hold_pend = 1'b0;
    logic [32:0] hold_val  = '0;
    logic [31:0] hold_dat  = '0;

    assign ACK_I = STB_O && (wcnt >= wait_n);
    assign DAT_I = (patch_en && (ADR_O == 32'h300) && (rd300_cnt > 0)) ? 32'h1 : mem[ADR_O[9:0]];

    // observed bus transactions {we, adr, write data}
    logic [64:0] act_q [$];
    logic [64:0] exp_q [$];
    int          act_rd = 0;

    always @(posedge CLK_I) begin
        wcnt <= (STB_O && !ACK_I) ? wcnt + 1 : 0;
        if (RST_I && STB_O && ACK_I) begin
            act_q.push_back({WE_O, ADR_O, (WE_O ? DAT_O : 32'h0)});
            if (!WE_O && ADR_O == 32'h300) rd300_cnt <= rd300_cnt + 1;
        end
        if (RST_I && hold_pend && !(STB_O && {WE_O, ADR_O} == hold_val && DAT_O == hold_dat))
            stab_err <= stab_err + 1;
        if (RST_I && STB_O && !ACK_I) wait_seen <= wait_seen + 1;
        hold_pend <= RST_I && STB_O && !ACK_I;
        hold_val  <= {WE_O, ADR_O};
        hold_dat  <= DAT_O;
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [64:0] rd(input logic [31:0] a);
        return {1'b0, a, 32'h0};
    endfunction

    function automatic logic [64:0] wr(input logic [31:0] a, input logic [31:0] d);
        return {1'b1, a, d};
    endfunction

    function automatic logic [31:0] ins(input logic [3:0] op, input logic [27:0] operand);
        return {op, operand};
    endfunction

    // driver tasks
    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    endtask

    task automatic do_reset(input logic [31:0] boot);
        RST_I = 1'b0;
        ADR_I = boot;
        repeat (3) @(negedge CLK_I);
        check("rst_adr", ADR_O, 0);
        check("rst_dat", DAT_O, 0);
        check("rst_bus", {CYC_O, STB_O, WE_O, halt_o}, 0);
        check("rst_pc", pc_o, 0);
        act_rd = act_q.size();
        RST_I = 1'b1;
        @(negedge CLK_I);
        check("boot_fetch", {STB_O, CYC_O, WE_O, ADR_O}, {3'b110, boot});
    endtask

    task automatic run_halt(input string tag, input int max, output int cyc);
        cyc = 0;
        while (!halt_o && cyc < max) begin
            @(negedge CLK_I);
            cyc++;
        end
        check({"halt_", tag}, halt_o, 1);
    endtask

    task automatic drain(input string tag);
        logic [64:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (act_rd < act_q.size()) begin
                check({"bus_", tag}, act_q[act_rd], e);
                act_rd++;
            end else begin
                check({"bus_missing_", tag}, 65'h0, e);
            end
        end
        check({"bus_extra_", tag}, 65'(act_q.size() - act_rd), 0);
    endtask

    int cyc;
    int base_stab;
    int base_wait;
    int found;

    initial begin
        // reset/boot and arithmetic: LDI 5; ADDI -2; ST 0x200; HLT
        clear_mem();
        wait_n = 0;
        mem[10'h100] = ins(4'h1, 28'h5);
        mem[10'h101] = ins(4'hC, 28'hFFFFFFE);
        mem[10'h102] = ins(4'h3, 28'h200);
        mem[10'h103] = ins(4'hF, 28'h0);
        exp_q.push_back(rd(32'h100));
        exp_q.push_back(rd(32'h101));
        exp_q.push_back(rd(32'h102));
        exp_q.push_back(wr(32'h200, 32'h3));
        exp_q.push_back(rd(32'h103));
        do_reset(32'h100);
        check("boot_pc", pc_o, 32'h100);
        run_halt("arith", 100, cyc);
        check("arith_cycles", cyc, 8);
        check("arith_pc", pc_o, 32'h104);
        repeat (4) @(negedge CLK_I);
        check("arith_idle", {STB_O, CYC_O, WE_O}, 0);
        check("arith_adr_hold", ADR_O, 32'h103);
        drain("arith");

        // memory ALU with 2 wait states: LD 0x300; ADD 0x300; ST 0x301; HLT
        clear_mem();
        wait_n   = 2;
        patch_en = 1'b1;
        mem[10'h100] = ins(4'h2, 28'h300);
        mem[10'h101] = ins(4'h4, 28'h300);
        mem[10'h102] = ins(4'h3, 28'h301);
        mem[10'h103] = ins(4'hF, 28'h0);
        mem[10'h300] = 32'hFFFF_FFFF;
        exp_q.push_back(rd(32'h100));
        exp_q.push_back(rd(32'h300));
        exp_q.push_back(rd(32'h101));
        exp_q.push_back(rd(32'h300));
        exp_q.push_back(rd(32'h102));
        exp_q.push_back(wr(32'h301, 32'h0));
        exp_q.push_back(rd(32'h103));
        base_stab = stab_err;
        base_wait = wait_seen;
        do_reset(32'h100);
        run_halt("memalu", 300, cyc);
        check("memalu_pc", pc_o, 32'h104);
        check("memalu_stable", stab_err - base_stab, 0);
        check("memalu_waits", wait_seen - base_wait, 14);
        drain("memalu");
        patch_en = 1'b0;

        // branches: LDI 0; JZ 0x110; (LDI 7 skipped); LDI -1; JN 0x120; HLT
        clear_mem();
        wait_n = $urandom_range(0, 2);
        mem[10'h100] = ins(4'h1, 28'h0);
        mem[10'h101] = ins(4'hA, 28'h110);
        mem[10'h102] = ins(4'h1, 28'h7);
        mem[10'h110] = ins(4'h1, 28'hFFFFFFF);
        mem[10'h111] = ins(4'hB, 28'h120);
        mem[10'h120] = ins(4'hF, 28'h0);
        exp_q.push_back(rd(32'h100));
        exp_q.push_back(rd(32'h101));
        exp_q.push_back(rd(32'h110));
        exp_q.push_back(rd(32'h111));
        exp_q.push_back(rd(32'h120));
        do_reset(32'h100);
        run_halt("branch", 300, cyc);
        check("branch_pc", pc_o, 32'h121);
        drain("branch");

        // async reset in the middle of a waiting store, then reboot from 0x180
        clear_mem();
        wait_n = 3;
        mem[10'h100] = ins(4'h1, 28'h9);
        mem[10'h101] = ins(4'h3, 28'h200);
        mem[10'h180] = ins(4'hF, 28'h0);
        exp_q.push_back(rd(32'h100));
        exp_q.push_back(rd(32'h101));
        do_reset(32'h100);
        found = 0;
        for (int i = 0; i < 50 && found == 0; i++) begin
            if (STB_O && WE_O) found = 1;
            else @(negedge CLK_I);
        end
        check("midmem_store_seen", found, 1);
        check("midmem_store_data", {ADR_O, DAT_O}, {32'h200, 32'h9});
        #2 RST_I = 1'b0;
        #1;
        check("midmem_async_drop", {STB_O, CYC_O, WE_O}, 0);
        drain("midmem");
        wait_n = 0;
        exp_q.push_back(rd(32'h180));
        do_reset(32'h180);
        run_halt("reboot", 50, cyc);
        check("reboot_pc", pc_o, 32'h181);
        drain("reboot");

        // undefined opcode 0x8 followed by HLT
        clear_mem();
        wait_n = $urandom_range(0, 1);
        mem[10'h100] = ins(4'h8, 28'h0);
        mem[10'h101] = ins(4'hF, 28'h0);
        exp_q.push_back(rd(32'h100));
`ifdef CPU_ILLEGAL_TRAP_EN
        do_reset(32'h100);
        run_halt("illegal", 50, cyc);
        check("illegal_pc", pc_o, 32'h101);
`else
        exp_q.push_back(rd(32'h101));
        do_reset(32'h100);
        run_halt("illegal", 50, cyc);
        check("illegal_pc", pc_o, 32'h102);
`endif
        repeat (5) @(negedge CLK_I);
        check("illegal_idle", {STB_O, CYC_O, WE_O}, 0);
        drain("illegal");

        // final report
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/wb_cpu.md
Name: wb_cpu

Overview:
- Minimal 32-bit accumulator CPU with a single Wishbone-style classic master bus shared by instruction fetch and data access.
- Top-level compute block of the design, instantiated by the system top as `cpu`.
- Boots from an externally supplied address.
- Exposes PC and halt status for the verification interface.

Parameters:
- AW, 32, address width of ADR_I/ADR_O/pc_o.
- DW, 32, data/instruction width (fixed at 32; the ISA encoding depends on it).

Ports:
- CLK_I  in  1  system clock, rising edge.
- RST_I  in  1  asynchronous, active-low reset.
- ADR_I  in  AW  boot vector; sampled in BOOT state.
- ADR_O  out  AW  bus address (word address).
- DAT_I  in  DW  bus read data / instruction.
- DAT_O  out  DW  bus write data.
- CYC_O  out  1  bus cycle active; always equal to STB_O.
- STB_O  out  1  bus strobe.
- WE_O  out  1  1 = write.
- ACK_I  in  1  slave acknowledge; may be asserted in the same cycle as STB_O.
- pc_o  out  AW  current program counter.
- halt_o  out  1  CPU halted.

Behaviour:
- Reset (RST_I=0, async): state=BOOT; pc, acc, ir, ADR_O, DAT_O = 0; CYC_O, STB_O, WE_O, halt_o = 0.
- BOOT (one cycle after reset release): pc <= ADR_I, then go to FETCH.
- FETCH: CYC_O=STB_O=1, WE_O=0, ADR_O=pc.
  - Hold until ACK_I is sampled high on a rising edge.
  - Then ir <= DAT_I, pc <= pc+1 (mod 2^AW).
  - Go to MEM for opcodes 2–7, 0xD, 0xE (0xD/0xE use MEM for their data read); otherwise go to EXEC.
- Instruction format: op = ir[31:28], operand = ir[27:0].
  - Addresses: operand zero-extended.
  - Immediates: operand sign-extended from bit 27.
- EXEC (1 cycle, no bus activity), by opcode:
  - 0x0 NOP.
  - 0x1 LDI: acc <= imm.
  - 0x9 JMP: pc <= addr.
  - 0xA JZ: if acc==0 then pc <= addr.
  - 0xB JN: if acc[31] then pc <= addr.
  - 0xC ADDI: acc <= acc+imm.
  - 0xF HLT: go to HALT.
  - 0x8 and other undefined opcodes: NOP (see optional feature).
  - After EXEC, next state is FETCH, except HLT.
- MEM: CYC_O=STB_O=1, ADR_O=addr.
  - Opcode 3 ST: WE_O=1, DAT_O=acc.
  - All other MEM opcodes: WE_O=0.
  - On ACK_I, by opcode:
    - 2 LD: acc <= DAT_I.
    - 3 ST: no register update.
    - 4 ADD: acc <= acc+DAT_I.
    - 5 SUB: acc <= acc−DAT_I.
    - 6 AND: acc <= acc & DAT_I.
    - 7 OR: acc <= acc | DAT_I.
    - 0xD XOR: acc <= acc ^ DAT_I.
    - 0xE: same result as LD (acc <= DAT_I).
  - Then go to FETCH.
- Arithmetic: 32-bit wrap-around, no flags stored.
- HALT: halt_o=1, bus idle, stays until reset.
- Outside FETCH/MEM:
  - STB_O=CYC_O=WE_O=0.
  - ADR_O and DAT_O hold their last value.
- Timing: zero-wait slave gives 2 cycles per instruction. Each wait cycle (ACK_I low) extends the current bus phase by 1 cycle; outputs are stable while waiting.
- ACK_I outside a bus phase is ignored.
- Reset asserted mid-bus-phase: STB_O drops immediately (async); the transaction is abandoned.
- pc_o always equals the internal pc.

Optional Feature:
- Macro CPU_ILLEGAL_TRAP_EN.
- Defined: undefined opcode 0x8 in EXEC drives halt_o=1 and enters HALT; pc_o points to the instruction after the illegal one.
- Undefined: 0x8 executes as NOP and the CPU continues.

Test Plan:
- Reset/boot: hold RST_I=0 for 3 cycles, ADR_I=0x100, release → all outputs 0 during reset; first STB_O with ADR_O=0x100, WE_O=0.
- Arithmetic: program at 0x100 = LDI 5, ADDI −2, ST 0x200, HLT, zero-wait memory → write to 0x200 with DAT_O=3, WE_O=1; halt_o=1 after 8 cycles of execution; pc_o=0x104.
- Memory ALU with wait states: mem[0x300]=0xFFFF_FFFF; program LD 0x300, ADD 0x300 (value 1 preloaded at 0x300 after first read), ST 0x301; ACK delayed 2 cycles → ST data 0x0000_0000 (wrap); STB_O/ADR_O stable during waits.
- Branches: LDI 0; JZ 0x110; LDI 7 at 0x102 must not execute; at 0x110 LDI −1; JN 0x120 → fetch addresses 0x100, 0x101, 0x110, 0x111, 0x120.
- Async reset mid-MEM: assert RST_I low while STB_O=1, WE_O=1 → STB_O/WE_O drop within the same cycle (no clock edge needed); restart re-fetches from the new ADR_I.
- Illegal opcode 0x8xxxxxxx → with CPU_ILLEGAL_TRAP_EN, halt_o=1 and no further fetch; without it, the next sequential fetch occurs.
